// File: rtl/adc_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble) feeding the display mux.
// One sample per handshake; digits are held stable between conversions.
module adc_bcd_converter #(
    parameter int IN_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [IN_WIDTH-1:0] sample_data,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [3:0]          digit0,
    output logic [3:0]          digit1,
    output logic [3:0]          digit2
);

    localparam int SW = 12 + IN_WIDTH;
    localparam int CW = $clog2(IN_WIDTH + 1);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST_ITER = CW'(IN_WIDTH - 1);

    logic [0:0]          state;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adjusted;
    logic [SW-1:0]       shifted;
    logic [CW-1:0]       count;
    logic                ovf_pending;
    logic                too_big;
    logic [IN_WIDTH-1:0] operand_in;

    // Clamp compares the full input; for narrow inputs it can never fire.
    assign too_big    = 32'(sample_data) > 32'd999;
    assign operand_in = too_big ? IN_WIDTH'(999) : sample_data;

    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[IN_WIDTH+4*i +: 4] >= 4'd5)
                adjusted[IN_WIDTH+4*i +: 4] = scratch[IN_WIDTH+4*i +: 4] + 4'd3;
        end
        shifted = {adjusted[SW-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STATE_IDLE;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            digit0      <= 4'd0;
            digit1      <= 4'd0;
            digit2      <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (sample_valid) begin
                        scratch     <= {12'd0, operand_in};
                        ovf_pending <= too_big;
                        count       <= '0;
                        busy        <= 1'b1;
                        state       <= STATE_SHIFT;
                    end
                end
                STATE_SHIFT: begin
                    scratch <= shifted;
                    count   <= count + 1'b1;
                    // Digits publish only here so the display never sees partials.
                    if (count == LAST_ITER) begin
                        digit0   <= shifted[IN_WIDTH +: 4];
                        digit1   <= shifted[IN_WIDTH+4 +: 4];
                        digit2   <= shifted[IN_WIDTH+8 +: 4];
                        overflow <= ovf_pending;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= STATE_IDLE;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_bcd_converter.sv
// Scoreboard bench for adc_bcd_converter: driver predicts results from
// decimal arithmetic, monitor checks every cycle after the clock edge.
module tb_adc_bcd_converter;

    localparam int W = 10;
    localparam int LAT = W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_valid = 1'b0;
    logic [W-1:0] sample_data = '0;
    logic         busy, done, overflow;
    logic [3:0]   digit0, digit1, digit2;

    typedef struct {
        int         edge_no;
        logic [3:0] d2, d1, d0;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    exp_t disp;
    int   edge_cnt = 0;
    int   next_ok = 0;
    int   checks = 0;
    int   errors = 0;

    adc_bcd_converter #(.IN_WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .digit0(digit0),
        .digit1(digit1),
        .digit2(digit2)
    );

    always #5 clk = ~clk;

    function automatic exp_t ref_model(input int v, input int e);
        exp_t r;
        int c;
        c = (v > 999) ? 999 : v;
        r.edge_no = e;
        r.d2  = 4'(c / 100);
        r.d1  = 4'((c / 10) % 10);
        r.d0  = 4'(c % 10);
        r.ovf = (v > 999);
        return r;
    endfunction

    task automatic drive(input logic rst, input logic v, input int d);
        int e;
        @(negedge clk);
        reset = rst;
        sample_valid = v;
        sample_data = W'(d);
        e = edge_cnt + 1;
        if (rst) begin
            q.delete();
            disp = ref_model(0, 0);
            next_ok = 0;
        end else if (v && e >= next_ok) begin
            q.push_back(ref_model(d, e + LAT));
            next_ok = e + LAT + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    always @(posedge clk) begin
        logic exp_done;
        edge_cnt++;
        #1;
        exp_done = (q.size() != 0) && (q[0].edge_no == edge_cnt);
        checks++;
        if (done !== exp_done) begin
            errors++;
            $display("FAIL done @edge %0d: got %b want %b", edge_cnt, done, exp_done);
        end
        if (exp_done) disp = q.pop_front();
        checks++;
        if (busy !== (q.size() != 0)) begin
            errors++;
            $display("FAIL busy @edge %0d: got %b want %b", edge_cnt, busy, q.size() != 0);
        end
        checks++;
        if ({digit2, digit1, digit0, overflow} !== {disp.d2, disp.d1, disp.d0, disp.ovf}) begin
            errors++;
            $display("FAIL digits @edge %0d: got %0d/%0d/%0d ovf=%b want %0d/%0d/%0d ovf=%b",
                     edge_cnt, digit2, digit1, digit0, overflow,
                     disp.d2, disp.d1, disp.d0, disp.ovf);
        end
    end

    initial begin
        int n;
        disp = ref_model(0, 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 0);
        idle(2);

        drive(1'b0, 1'b1, 742);
        idle(12);

        drive(1'b0, 1'b1, 1023);
        idle(11);
        drive(1'b0, 1'b1, 0);
        idle(11);

        drive(1'b0, 1'b1, 305);
        idle(3);
        drive(1'b0, 1'b1, 999);
        idle(8);

        drive(1'b0, 1'b1, 58);
        idle(4);
        drive(1'b1, 1'b1, 77);
        drive(1'b0, 1'b1, 9);
        idle(12);

        for (int v = 1; v <= 60; v++) drive(1'b0, 1'b1, v);
        idle(12);

        for (int v = 0; v < 1024; v++) begin
            drive(1'b0, 1'b1, v);
            idle(LAT);
        end

        for (int i = 0; i < 1500; i++)
            drive(1'b0, ($urandom_range(0, 2) != 0), $urandom_range(0, 1023));
        drive(1'b0, 1'b1, $urandom_range(0, 1023));
        drive(1'b1, 1'b0, 0);

        drive(1'b0, 1'b1, $urandom_range(0, 1023));
        n = 0;
        while (q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", q.size());
        end
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
